pe_grad_pipe: RTL and testbench
===============================

PE_GRAD_PIPE -- requirements
Module: pe_grad_pipe

Interface
REQ-001 SHALL have parameter PIXEL_W, default 12, the unsigned pixel width.
REQ-002 SHALL have parameter FRAC_W, default 8, the weight width; the divider takes one cycle per weight bit.
REQ-003 SHALL derive G_W = PIXEL_W+4 as the gradient width; G_W is not overridable.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  input  1  clock, all state on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  request; sampled only in IDLE.
REQ-007 win  input  25*PIXEL_W  5x5 window, row-major; element k = r*5+c at bits [k*PIXEL_W +: PIXEL_W]; r=0 is row -2, c=0 is column -2.
REQ-008 busy  output  1  high whenever the state is not IDLE.
REQ-009 done  output  1  one-cycle pulse when the results update.
REQ-010 grad_hs  output  G_W  absolute horizontal gradient.
REQ-011 grad_vs  output  G_W  absolute vertical gradient.
REQ-012 w_hs  output  FRAC_W  horizontal weight.
REQ-013 w_vs  output  FRAC_W  vertical weight.

Function
REQ-014 SHALL implement the FSM IDLE -> SUM -> GRAD -> DIV -> DONE -> IDLE.
REQ-015 IDLE: when start=1, SHALL register win and go to SUM; start in any other state SHALL be ignored and not queued.
REQ-016 SUM: SHALL register the five column sums C1..C5 and the five row sums R1..R5, each PIXEL_W+3 bits, unsigned.
REQ-017 GRAD: SHALL register the results of both definitions below, computed in signed G_W+1 bits:
- hs = |2*C4 + C5 - 2*C2 - C1|
- vs = |2*R4 + R5 - 2*R2 - R1|
REQ-018 GRAD: SHALL apply the zero fix for the divider only: if hs=0 and vs=0, use hs'=vs'=1; otherwise hs'=hs and vs'=vs.
REQ-019 GRAD: SHALL load divisor = hs'+vs' (G_W+1 bits).
REQ-020 GRAD: SHALL load dividend = hs'*2^FRAC_W - 1 when hs'>0, else 0.
REQ-021 GRAD: SHALL clear the iteration counter.
REQ-022 DIV: SHALL run an unsigned restoring division, one quotient bit per cycle, MSB first, for exactly FRAC_W cycles, then go to DONE.
REQ-023 DONE: SHALL load the outputs as follows, assert done for this cycle only, and return to IDLE:
- grad_hs = hs, grad_vs = vs (true values, not zero-fixed)
- w_hs = the quotient
- w_vs = (2^FRAC_W - 1) - w_hs
REQ-024 Latency: done SHALL be high in exactly the cycle FRAC_W+3 clocks after the start-accepting edge (11 for default parameters).
REQ-025 Throughput: one result per FRAC_W+4 cycles; start SHALL NOT be accepted in the DONE cycle.
REQ-026 The quotient SHALL always fit in FRAC_W bits, because dividend < divisor*2^FRAC_W; no saturation logic is required.
REQ-027 Outputs SHALL hold their values between done pulses.
REQ-028 win changes after acceptance SHALL NOT affect the result in flight.

Reset
REQ-029 While rst=1, the state SHALL go to IDLE, and busy, done, grad_hs, grad_vs, w_hs and w_vs SHALL all be 0.
REQ-030 rst SHALL have priority over start.
REQ-031 rst asserted in any state, including DIV, SHALL abort the operation with no done pulse.
REQ-032 The first start after rst deasserts SHALL be accepted normally.

Verification (PIXEL_W=12, FRAC_W=8)
REQ-033 Flat window, all pixels 100 -> grad_hs=0, grad_vs=0, w_hs=127, w_vs=128; done exactly 11 cycles after start.
REQ-034 Horizontal ramp, pixel = c*100 -> grad_hs=4000, grad_vs=0, w_hs=255, w_vs=0.
REQ-035 Vertical ramp, pixel = r*100 -> grad_hs=0, grad_vs=4000, w_hs=0, w_vs=255.
REQ-036 Diagonal ramp, pixel = (r+c)*100 -> grad_hs=4000, grad_vs=4000, w_hs=127, w_vs=128.
REQ-037 Extreme: columns c=3,4 = 4095, all others 0 -> grad_hs=61425, grad_vs=0, w_hs=255, w_vs=0 (no overflow).
REQ-038 Control:
- start pulses while busy -> ignored, exactly one done.
- rst during DIV -> all outputs 0, no done.
- Next start -> correct result after 11 cycles.

Source files
------------

// File: rtl/pe_grad_pipe.sv
// pe_grad_pipe
// Gradient and weight engine for a 5x5 pixel window. Takes column and row
// sums, forms the absolute horizontal and vertical gradients, then divides
// to get a horizontal weight w_hs = (hs*2^FRAC_W - 1)/(hs + vs) and a
// complementary vertical weight w_vs = (2^FRAC_W - 1) - w_hs.
//
// Ports
//   clk      clock, all state on the rising edge
//   rst      synchronous active-high reset; aborts any operation in flight
//   start    request, only sampled in IDLE
//   win      5x5 window, row-major, element k = r*5+c at [k*PIXEL_W +: PIXEL_W]
//   busy     high whenever the FSM is not in IDLE
//   done     one-cycle pulse when the outputs update
//   grad_hs  absolute horizontal gradient
//   grad_vs  absolute vertical gradient
//   w_hs     horizontal weight
//   w_vs     vertical weight
//
// state | meaning
// IDLE  | waiting for start; window captured on acceptance
// SUM   | column and row sums registered
// GRAD  | gradients registered, divider operands loaded
// DIV   | restoring division, one quotient bit per cycle, FRAC_W cycles
// DONE  | outputs loaded, done pulsed, back to IDLE
module pe_grad_pipe #(
    parameter int PIXEL_W = 12,
    parameter int FRAC_W  = 8,
    localparam int G_W    = PIXEL_W + 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [25*PIXEL_W-1:0]  win,
    output logic                   busy,
    output logic                   done,
    output logic [G_W-1:0]         grad_hs,
    output logic [G_W-1:0]         grad_vs,
    output logic [FRAC_W-1:0]      w_hs,
    output logic [FRAC_W-1:0]      w_vs
);

    localparam int S_W   = PIXEL_W + 3;
    localparam int D_W   = G_W + 1;
    localparam int N_W   = G_W + FRAC_W;
    localparam int CNT_W = $clog2(FRAC_W) + 1;

    typedef enum logic [2:0] {IDLE, SUM, GRAD, DIV, DONE} state_t;

    state_t               state;
    logic [25*PIXEL_W-1:0] win_q;
    logic [S_W-1:0]       col_q [5];
    logic [S_W-1:0]       row_q [5];
    logic [S_W-1:0]       col_c [5];
    logic [S_W-1:0]       row_c [5];
    logic [G_W-1:0]       hs_q, vs_q;
    logic [D_W-1:0]       divisor, rem;
    logic [FRAC_W-1:0]    low, quot;
    logic [CNT_W-1:0]     cnt;

    logic signed [D_W-1:0] hs_s, vs_s;
    logic [G_W-1:0]        hs_mag, vs_mag, hs_fix, vs_fix;
    logic [D_W-1:0]        divisor_n;
    logic [N_W-1:0]        dividend_n;
    logic [D_W:0]          trial;
    logic                  q_bit;
    logic [D_W-1:0]        rem_n;

    assign busy = (state != IDLE);

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            col_c[i] = '0;
            row_c[i] = '0;
        end
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                col_c[c] = col_c[c] + S_W'(win_q[(r*5+c)*PIXEL_W +: PIXEL_W]);
                row_c[r] = row_c[r] + S_W'(win_q[(r*5+c)*PIXEL_W +: PIXEL_W]);
            end
        end
    end

    // Sums are zero-extended into the signed D_W domain; 2*x is a left shift.
    always_comb begin
        hs_s = $signed({1'b0, col_q[3], 1'b0}) + $signed({2'b00, col_q[4]})
             - $signed({1'b0, col_q[1], 1'b0}) - $signed({2'b00, col_q[0]});
        vs_s = $signed({1'b0, row_q[3], 1'b0}) + $signed({2'b00, row_q[4]})
             - $signed({1'b0, row_q[1], 1'b0}) - $signed({2'b00, row_q[0]});
        hs_mag = hs_s[D_W-1] ? G_W'(-hs_s) : G_W'(hs_s);
        vs_mag = vs_s[D_W-1] ? G_W'(-vs_s) : G_W'(vs_s);
        // Flat window: avoid 0/0 by treating both gradients as 1.
        if (hs_mag == '0 && vs_mag == '0) begin
            hs_fix = G_W'(1);
            vs_fix = G_W'(1);
        end else begin
            hs_fix = hs_mag;
            vs_fix = vs_mag;
        end
        divisor_n = {1'b0, hs_fix} + {1'b0, vs_fix};
        if (hs_fix != '0)
            dividend_n = {hs_fix, {FRAC_W{1'b0}}} - N_W'(1);
        else
            dividend_n = '0;
    end

    // The upper dividend bits are always below the divisor, so they seed the
    // remainder and only the FRAC_W low bits are shifted through.
    always_comb begin
        trial = {rem, low[FRAC_W-1]};
        q_bit = (trial >= {1'b0, divisor});
        rem_n = q_bit ? D_W'(trial - {1'b0, divisor}) : D_W'(trial);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            done    <= 1'b0;
            grad_hs <= '0;
            grad_vs <= '0;
            w_hs    <= '0;
            w_vs    <= '0;
            win_q   <= '0;
            for (int i = 0; i < 5; i++) begin
                col_q[i] <= '0;
                row_q[i] <= '0;
            end
            hs_q    <= '0;
            vs_q    <= '0;
            divisor <= '0;
            rem     <= '0;
            low     <= '0;
            quot    <= '0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        win_q <= win;
                        state <= SUM;
                    end
                end
                SUM: begin
                    col_q <= col_c;
                    row_q <= row_c;
                    state <= GRAD;
                end
                GRAD: begin
                    hs_q    <= hs_mag;
                    vs_q    <= vs_mag;
                    divisor <= divisor_n;
                    rem     <= {1'b0, dividend_n[N_W-1:FRAC_W]};
                    low     <= dividend_n[FRAC_W-1:0];
                    quot    <= '0;
                    cnt     <= '0;
                    state   <= DIV;
                end
                DIV: begin
                    rem  <= rem_n;
                    low  <= low << 1;
                    quot <= FRAC_W'({quot, q_bit});
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(FRAC_W - 1))
                        state <= DONE;
                end
                DONE: begin
                    grad_hs <= hs_q;
                    grad_vs <= vs_q;
                    w_hs    <= quot;
                    w_vs    <= {FRAC_W{1'b1}} - quot;
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_grad_pipe.sv
// tb_pe_grad_pipe
// Directed bench for pe_grad_pipe with PIXEL_W=12, FRAC_W=8. Inputs are
// driven and outputs sampled on the falling edge.
module tb_pe_grad_pipe;

    localparam int PIXEL_W = 12;
    localparam int FRAC_W  = 8;
    localparam int G_W     = PIXEL_W + 4;
    localparam int WIN_W   = 25 * PIXEL_W;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [WIN_W-1:0]   win;
    logic               busy;
    logic               done;
    logic [G_W-1:0]     grad_hs;
    logic [G_W-1:0]     grad_vs;
    logic [FRAC_W-1:0]  w_hs;
    logic [FRAC_W-1:0]  w_vs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pe_grad_pipe #(.PIXEL_W(PIXEL_W), .FRAC_W(FRAC_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .win     (win),
        .busy    (busy),
        .done    (done),
        .grad_hs (grad_hs),
        .grad_vs (grad_vs),
        .w_hs    (w_hs),
        .w_vs    (w_vs)
    );

    // 0 flat 100, 1 pixel=c*100, 2 pixel=r*100, 3 pixel=(r+c)*100,
    // 4 columns 3,4 at full scale
    function automatic logic [WIN_W-1:0] mk_win(input int mode);
        logic [WIN_W-1:0] w;
        int p;
        w = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                case (mode)
                    0: p = 100;
                    1: p = c * 100;
                    2: p = r * 100;
                    3: p = (r + c) * 100;
                    4: p = (c >= 3) ? 4095 : 0;
                    default: p = 0;
                endcase
                w[(r*5+c)*PIXEL_W +: PIXEL_W] = p[PIXEL_W-1:0];
            end
        end
        return w;
    endfunction

    // Launches one operation, scrambles win after acceptance, and returns
    // the number of cycles from the accepting edge to done (-1 on timeout).
    task automatic run_op(input logic [WIN_W-1:0] w, output int lat);
        @(negedge clk);
        win   = w;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        win   = ~w;
        lat   = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        win   = mk_win(3);
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0d want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0d want 0", done); end
        checks++; if ({grad_hs, grad_vs, w_hs, w_vs} !== '0) begin errors++;
            $display("FAIL reset_outs got %0d %0d %0d %0d want all 0", grad_hs, grad_vs, w_hs, w_vs); end
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_prio_busy got %0d want 0", busy); end
    endtask

    task automatic test_flat();
        int lat;
        run_op(mk_win(0), lat);
        checks++; if (lat !== 11) begin errors++; $display("FAIL flat_latency got %0d want 11", lat); end
        checks++; if (grad_hs !== 16'd0 || grad_vs !== 16'd0) begin errors++;
            $display("FAIL flat_grad got %0d %0d want 0 0", grad_hs, grad_vs); end
        checks++; if (w_hs !== 8'd127 || w_vs !== 8'd128) begin errors++;
            $display("FAIL flat_weight got %0d %0d want 127 128", w_hs, w_vs); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flat_busy_at_done got %0d want 0", busy); end
        repeat (5) @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL flat_done_pulse got %0d want 0", done); end
        checks++; if (w_hs !== 8'd127 || w_vs !== 8'd128 || grad_hs !== 16'd0) begin errors++;
            $display("FAIL flat_hold got %0d %0d %0d want 127 128 0", w_hs, w_vs, grad_hs); end
    endtask

    task automatic test_hramp();
        int lat;
        run_op(mk_win(1), lat);
        checks++; if (lat !== 11) begin errors++; $display("FAIL hramp_latency got %0d want 11", lat); end
        checks++; if (grad_hs !== 16'd4000 || grad_vs !== 16'd0) begin errors++;
            $display("FAIL hramp_grad got %0d %0d want 4000 0", grad_hs, grad_vs); end
        checks++; if (w_hs !== 8'd255 || w_vs !== 8'd0) begin errors++;
            $display("FAIL hramp_weight got %0d %0d want 255 0", w_hs, w_vs); end
    endtask

    task automatic test_vramp();
        int lat;
        run_op(mk_win(2), lat);
        checks++; if (lat !== 11) begin errors++; $display("FAIL vramp_latency got %0d want 11", lat); end
        checks++; if (grad_hs !== 16'd0 || grad_vs !== 16'd4000) begin errors++;
            $display("FAIL vramp_grad got %0d %0d want 0 4000", grad_hs, grad_vs); end
        checks++; if (w_hs !== 8'd0 || w_vs !== 8'd255) begin errors++;
            $display("FAIL vramp_weight got %0d %0d want 0 255", w_hs, w_vs); end
    endtask

    task automatic test_diag();
        int lat;
        run_op(mk_win(3), lat);
        checks++; if (lat !== 11) begin errors++; $display("FAIL diag_latency got %0d want 11", lat); end
        checks++; if (grad_hs !== 16'd4000 || grad_vs !== 16'd4000) begin errors++;
            $display("FAIL diag_grad got %0d %0d want 4000 4000", grad_hs, grad_vs); end
        checks++; if (w_hs !== 8'd127 || w_vs !== 8'd128) begin errors++;
            $display("FAIL diag_weight got %0d %0d want 127 128", w_hs, w_vs); end
    endtask

    task automatic test_extreme();
        int lat;
        run_op(mk_win(4), lat);
        checks++; if (lat !== 11) begin errors++; $display("FAIL extreme_latency got %0d want 11", lat); end
        checks++; if (grad_hs !== 16'd61425 || grad_vs !== 16'd0) begin errors++;
            $display("FAIL extreme_grad got %0d %0d want 61425 0", grad_hs, grad_vs); end
        checks++; if (w_hs !== 8'd255 || w_vs !== 8'd0) begin errors++;
            $display("FAIL extreme_weight got %0d %0d want 255 0", w_hs, w_vs); end
    endtask

    // start held high through the whole operation including the DONE cycle,
    // then dropped before the FSM could take it again.
    task automatic test_busy_ignore();
        int n_done = 0;
        int at = -1;
        @(negedge clk);
        win   = mk_win(1);
        start = 1'b1;
        @(negedge clk);
        win   = mk_win(2);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 11) start = 1'b0;
            if (done) begin
                n_done++;
                at = i;
            end
            if (i == 5) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy_mid got %0d want 1", busy); end
            end
        end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", n_done); end
        checks++; if (at !== 11) begin errors++; $display("FAIL ignore_done_cycle got %0d want 11", at); end
        checks++; if (grad_hs !== 16'd4000 || w_hs !== 8'd255) begin errors++;
            $display("FAIL ignore_result got %0d %0d want 4000 255", grad_hs, w_hs); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy_end got %0d want 0", busy); end
    endtask

    // start held continuously: accepted every FRAC_W+4 cycles.
    task automatic test_back_to_back();
        int n_done = 0;
        @(negedge clk);
        win   = mk_win(1);
        start = 1'b1;
        @(negedge clk);
        win   = mk_win(2);
        for (int i = 1; i <= 35; i++) begin
            @(negedge clk);
            if (i == 12) start = 1'b0;
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    checks++; if (i !== 11) begin errors++; $display("FAIL b2b_first_cycle got %0d want 11", i); end
                    checks++; if (grad_hs !== 16'd4000 || grad_vs !== 16'd0 || w_hs !== 8'd255) begin errors++;
                        $display("FAIL b2b_first_result got %0d %0d %0d want 4000 0 255", grad_hs, grad_vs, w_hs); end
                end else if (n_done == 2) begin
                    checks++; if (i !== 23) begin errors++; $display("FAIL b2b_second_cycle got %0d want 23", i); end
                    checks++; if (grad_hs !== 16'd0 || grad_vs !== 16'd4000 || w_vs !== 8'd255) begin errors++;
                        $display("FAIL b2b_second_result got %0d %0d %0d want 0 4000 255", grad_hs, grad_vs, w_vs); end
                end
            end
        end
        checks++; if (n_done !== 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", n_done); end
    endtask

    task automatic test_rst_during_div();
        int n_done = 0;
        int lat;
        @(negedge clk);
        win   = mk_win(1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) n_done++;
            if (i == 5) rst = 1'b1;
            if (i == 6) begin
                checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
                    $display("FAIL abort_ctrl got busy=%0d done=%0d want 0 0", busy, done); end
                checks++; if ({grad_hs, grad_vs, w_hs, w_vs} !== '0) begin errors++;
                    $display("FAIL abort_outs got %0d %0d %0d %0d want all 0", grad_hs, grad_vs, w_hs, w_vs); end
            end
            if (i == 7) rst = 1'b0;
        end
        checks++; if (n_done !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", n_done); end
        run_op(mk_win(3), lat);
        checks++; if (lat !== 11) begin errors++; $display("FAIL after_rst_latency got %0d want 11", lat); end
        checks++; if (grad_hs !== 16'd4000 || grad_vs !== 16'd4000 || w_hs !== 8'd127 || w_vs !== 8'd128) begin errors++;
            $display("FAIL after_rst_result got %0d %0d %0d %0d want 4000 4000 127 128", grad_hs, grad_vs, w_hs, w_vs); end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        win   = '0;
        test_reset();
        test_flat();
        test_hramp();
        test_vramp();
        test_diag();
        test_extreme();
        test_busy_ignore();
        test_back_to_back();
        test_rst_during_div();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
